// File: rtl/lsu_bus_bridge_pkg.sv
// Shared codes and helpers for the load/store bus bridge.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package lsu_bus_bridge_pkg;

  localparam int XLEN_DEF = 32;

  // RV32I load/store Funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_e;

  // Width code 11 has no RV32I meaning and is handled as a word access.
  function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] lo);
    logic r;
    if (f3[1:0] == F3_SB[1:0])      r = 1'b0;
    else if (f3[1:0] == F3_SH[1:0]) r = lo[0];
    else                            r = |lo;
    return r;
  endfunction

  function automatic logic [3:0] byte_en(logic [2:0] f3, logic [1:0] lo);
    logic [3:0] r;
    if (f3[1:0] == F3_SB[1:0])      r = 4'b0001 << lo;
    else if (f3[1:0] == F3_SH[1:0]) r = 4'b0011 << {lo[1], 1'b0};
    else                            r = 4'b1111;
    return r;
  endfunction

  // Replicate the store operand so every enabled lane carries the right bytes.
  function automatic logic [31:0] store_lanes(logic [2:0] f3, logic [31:0] d);
    logic [31:0] r;
    if (f3[1:0] == F3_SB[1:0])      r = {4{d[7:0]}};
    else if (f3[1:0] == F3_SH[1:0]) r = {2{d[15:0]}};
    else if (f3[1:0] == F3_SW[1:0]) r = d;
    else                            r = d;
    return r;
  endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load lane select plus sign/zero extension of the bus read word.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is captured.
module lsu_ld_align
  import lsu_bus_bridge_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte/halfword, then extend according to the load type
  always_comb begin
    lane_b  = rdata[{addr_lo, 3'b000} +: 8];
    lane_h  = rdata[{addr_lo[1], 4'b0000} +: 16];
    ld_data = rdata;
    case (funct3)
      F3_LB:   ld_data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, lane_b};
      F3_LH:   ld_data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, lane_h};
      F3_LW:   ld_data = rdata;
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store unit bridging the core's data port to a req/ready/rvalid memory bus.
// Latency: 1 stall cycle + bus wait cycles; result visible in the single DONE cycle.
// Backpressure: Stall holds the core until Bus_Ready/Bus_RValid arrive or TIMEOUT expires.
module lsu_bus_bridge
  import lsu_bus_bridge_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16   // needs 2**CNT_W > TIMEOUT
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            Mem_Rd,
  input  logic            Mem_Wr,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] Wr_Data,
  output logic [XLEN-1:0] Ld_Data,
  output logic            Stall,
  output logic            Misaligned,
  output logic            Bus_Err,
  output logic            Bus_Req,
  output logic            Bus_We,
  output logic [XLEN-1:0] Bus_Addr,
  output logic [3:0]      Bus_Be,
  output logic [XLEN-1:0] Bus_WData,
  input  logic            Bus_Ready,
  input  logic            Bus_RValid,
  input  logic [XLEN-1:0] Bus_RData
);

  lsu_state_e       state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             acc, is_store, misal, tmo_hit;
  logic             capture, err_set, mis_set;
  logic [XLEN-1:0]  ld_aligned;

  assign acc      = Mem_Rd | Mem_Wr;
  assign is_store = Mem_Wr;   // store wins if both strobes are up
  assign misal    = is_misaligned(Funct3, Addr[1:0]);
  assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  lsu_ld_align #(.XLEN(XLEN)) u_ld_align (
    .rdata   (Bus_RData),
    .addr_lo (Addr[1:0]),
    .funct3  (Funct3),
    .ld_data (ld_aligned)
  );

  // Bus side is driven straight from the core's held inputs while in REQ
  assign Bus_Req   = (state == ST_REQ);
  assign Bus_We    = Bus_Req & is_store;
  assign Bus_Addr  = Bus_Req ? {Addr[XLEN-1:2], 2'b00} : '0;
  assign Bus_Be    = Bus_Req ? byte_en(Funct3, Addr[1:0]) : 4'b0000;
  assign Bus_WData = Bus_Req ? store_lanes(Funct3, Wr_Data) : '0;

  // Reset gates Stall so the core is released the moment rst_n drops
  assign Stall = rst_n & acc & (state != ST_DONE);

  // Next-state and per-transition strobes
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    err_set   = 1'b0;
    mis_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc) begin
          if (misal) begin
            state_nxt = ST_DONE;
            mis_set   = 1'b1;
          end else begin
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (Bus_Ready) begin
          if (is_store) begin
            state_nxt = ST_DONE;
          end else if (Bus_RValid) begin
            state_nxt = ST_DONE;
            capture   = 1'b1;
          end else begin
            state_nxt = ST_WAIT_R;
          end
        end else if (tmo_hit) begin
          state_nxt = ST_DONE;
          err_set   = 1'b1;
        end
      end
      ST_WAIT_R: begin
        if (Bus_RValid) begin
          state_nxt = ST_DONE;
          capture   = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = ST_DONE;
          err_set   = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Timeout counter: restarts on each new request, runs while waiting on the bus
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == ST_IDLE && state_nxt == ST_REQ) begin
      tmo_cnt <= '0;
    end else if (state == ST_REQ || state == ST_WAIT_R) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Load result register and the DONE-cycle status pulses
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      Ld_Data    <= '0;
      Misaligned <= 1'b0;
      Bus_Err    <= 1'b0;
    end else begin
      Misaligned <= mis_set;
      Bus_Err    <= err_set;
      if (capture)                   Ld_Data <= ld_aligned;
      else if (err_set && !is_store) Ld_Data <= '0;
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
module tb_lsu_bus_bridge;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        Mem_Rd = 1'b0, Mem_Wr = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] Addr = '0, Wr_Data = '0;
  logic [31:0] Ld_Data;
  logic        Stall, Misaligned, Bus_Err, Bus_Req, Bus_We;
  logic [31:0] Bus_Addr, Bus_WData;
  logic [3:0]  Bus_Be;
  logic        Bus_Ready = 1'b0, Bus_RValid = 1'b0;
  logic [31:0] Bus_RData = '0;

  always #5 CLK = ~CLK;

  lsu_bus_bridge #(.XLEN(32), .TIMEOUT(TO), .CNT_W(16)) dut (
    .CLK(CLK), .rst_n(rst_n), .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr), .Funct3(Funct3),
    .Addr(Addr), .Wr_Data(Wr_Data), .Ld_Data(Ld_Data), .Stall(Stall),
    .Misaligned(Misaligned), .Bus_Err(Bus_Err), .Bus_Req(Bus_Req), .Bus_We(Bus_We),
    .Bus_Addr(Bus_Addr), .Bus_Be(Bus_Be), .Bus_WData(Bus_WData),
    .Bus_Ready(Bus_Ready), .Bus_RValid(Bus_RValid), .Bus_RData(Bus_RData)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        mis;
    logic        err;
    logic [31:0] ld;
  } done_t;

  req_t        req_q[$];
  done_t       done_q[$];
  req_t        mon_req;
  done_t       mon_done;
  logic        done_cyc;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] model_ld = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic int sz_of(logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(logic [2:0] f3, logic [1:0] lo);
    int l = int'(lo);
    return (l % sz_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [1:0] lo);
    int sz = sz_of(f3);
    int l = int'(lo);
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) r[i] = (i >= l) && (i < l + sz);
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] d);
    int sz = sz_of(f3);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [1:0] lo, logic [31:0] rd);
    logic [31:0] s = rd >> (8 * int'(lo));
    int sz = sz_of(f3);
    if (sz == 1) return f3[2] ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    if (sz == 2) return f3[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    return s;
  endfunction

  // Monitor: pops expected bus requests on handshake and expected results in DONE
  always @(negedge CLK) begin
    if (rst_n) begin
      if (Bus_Req && Bus_Ready) begin
        if (req_q.size() == 0) begin
          check("req_unexpected", 1, 0);
        end else begin
          mon_req = req_q.pop_front();
          check("bus_we", Bus_We, mon_req.we);
          check("bus_addr", Bus_Addr, mon_req.addr);
          check("bus_be", Bus_Be, mon_req.be);
          check("bus_wdata", Bus_WData, mon_req.wdata);
        end
      end
      done_cyc = (Mem_Rd || Mem_Wr) && !Stall;
      if (done_cyc) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          mon_done = done_q.pop_front();
          check("misaligned", Misaligned, mon_done.mis);
          check("bus_err", Bus_Err, mon_done.err);
          check("ld_data", Ld_Data, mon_done.ld);
        end
      end else if (Misaligned || Bus_Err) begin
        check("stray_pulse", {Misaligned, Bus_Err}, 0);
      end
    end
  end

  // One core access; bus responder gives Ready after rdy_dly REQ cycles (-1 = never)
  // and RValid rv_dly cycles after Ready. Called and returns at posedge+1.
  task automatic access(input bit wr, input bit both, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int rdy_dly, input int rv_dly);
    bit    mis = m_mis(f3, addr[1:0]);
    bit    rdy_ok = (rdy_dly >= 0) && (rdy_dly < TO);
    bit    tmo = !mis && (!rdy_ok || (!wr && rdy_dly + 1 + rv_dly > TO));
    int    exp_stall, exp_reqs;
    int    n_stall = 0, n_req = 0, req_cyc = 0, post = 0, cyc = 0;
    bit    accepted = 0, fin = 0;
    req_t  r;
    done_t d;
    Mem_Wr = wr; Mem_Rd = !wr | both; Funct3 = f3; Addr = addr; Wr_Data = wd; Bus_RData = rd;
    if (!mis && rdy_ok) begin
      r.we = wr; r.addr = {addr[31:2], 2'b00}; r.be = m_be(f3, addr[1:0]); r.wdata = m_wdata(f3, wd);
      req_q.push_back(r);
    end
    if (!mis && !wr) model_ld = tmo ? 32'h0 : m_load(f3, addr[1:0], rd);
    d.mis = mis; d.err = tmo; d.ld = model_ld;
    done_q.push_back(d);
    exp_stall = mis ? 1 : (tmo ? 1 + TO : 2 + rdy_dly + (wr ? 0 : rv_dly));
    exp_reqs  = mis ? 0 : (rdy_ok ? rdy_dly + 1 : TO);
    while (!fin) begin
      Bus_Ready = 1'b0; Bus_RValid = 1'b0;
      if (Bus_Req) begin
        if (req_cyc == rdy_dly) begin
          Bus_Ready = 1'b1; accepted = 1;
          if (!wr && rv_dly == 0) Bus_RValid = 1'b1;
        end
        req_cyc++;
      end else if (accepted && !wr) begin
        post++;
        if (post == rv_dly) Bus_RValid = 1'b1;
      end
      @(negedge CLK);
      if (Stall) n_stall++; else fin = 1;
      if (Bus_Req) n_req++;
      @(posedge CLK); #1;
      cyc++;
      if (!fin && cyc > 40) begin
        check("access_bound", cyc, 0);
        fin = 1;
      end
    end
    Bus_Ready = 1'b0; Bus_RValid = 1'b0; Mem_Rd = 1'b0; Mem_Wr = 1'b0;
    check("stall_cycles", n_stall, exp_stall);
    check("req_cycles", n_req, exp_reqs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with a pending access on the core side
    Mem_Rd = 1'b1; Addr = 32'h104; Wr_Data = 32'h5A5A5A5A;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_stall", Stall, 0);
    check("rst_req", Bus_Req, 0);
    check("rst_be", Bus_Be, 0);
    check("rst_addr", Bus_Addr, 0);
    check("rst_wdata", Bus_WData, 0);
    check("rst_ld", Ld_Data, 0);
    check("rst_pulses", {Misaligned, Bus_Err, Bus_We}, 0);
    Mem_Rd = 1'b0;
    @(negedge CLK); rst_n = 1'b1;
    @(posedge CLK); #1;

    //     wr both f3      addr      wdata         rdata         rdy rv
    access(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,         0, 0);
    access(1, 0, 3'b000, 32'h103, 32'h000000A5, 32'h0,         0, 0);
    access(0, 0, 3'b000, 32'h102, 32'h0,        32'h12F63456,  0, 3);
    access(0, 0, 3'b100, 32'h102, 32'h0,        32'h12F63456,  0, 3);
    access(0, 0, 3'b001, 32'h102, 32'h0,        32'h12F63456,  0, 3);
    access(0, 0, 3'b010, 32'h101, 32'h0,        32'hFFFFFFFF,  0, 0);
    access(0, 0, 3'b101, 32'h100, 32'h0,        32'hABCD8001,  1, 0);
    access(0, 0, 3'b001, 32'h100, 32'h0,        32'hABCD8001,  0, 2);
    access(1, 0, 3'b001, 32'h106, 32'h1234BEEF, 32'h0,         2, 0);
    access(1, 0, 3'b001, 32'h101, 32'h1234BEEF, 32'h0,         0, 0);
    access(1, 1, 3'b000, 32'h101, 32'h0000007E, 32'h0,         1, 0);
    access(0, 0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D,  0, 0);
    access(0, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00,  0, 1);
    access(0, 0, 3'b011, 32'h110, 32'h0,        32'h0BADCAFE,  0, 0);
    access(0, 0, 3'b011, 32'h112, 32'h0,        32'h0BADCAFE,  0, 0);
    access(0, 0, 3'b010, 32'h108, 32'h0,        32'h77777777, -1, 0);
    access(0, 0, 3'b010, 32'h10C, 32'h0,        32'h11223344,  0, 1);
    access(0, 0, 3'b010, 32'h118, 32'h0,        32'h66666666,  0, 10);
    access(0, 0, 3'b010, 32'h10C, 32'h0,        32'h11223344,  0, 1);
    access(1, 0, 3'b010, 32'h120, 32'h87654321, 32'h0,        -1, 0);

    // Reset while waiting for read data
    Mem_Rd = 1'b1; Funct3 = 3'b010; Addr = 32'h200; Wr_Data = '0; Bus_RData = 32'h55AA55AA;
    begin
      req_t r;
      r.we = 1'b0; r.addr = 32'h200; r.be = 4'hF; r.wdata = 32'h0;
      req_q.push_back(r);
    end
    @(posedge CLK); #1;
    check("rstw_req_up", Bus_Req, 1);
    Bus_Ready = 1'b1;
    @(posedge CLK); #1;
    Bus_Ready = 1'b0;
    @(negedge CLK);
    check("rstw_wait_req", Bus_Req, 0);
    check("rstw_wait_stall", Stall, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_req", Bus_Req, 0);
    check("rstw_stall", Stall, 0);
    check("rstw_ld", Ld_Data, 0);
    req_q.delete(); done_q.delete(); model_ld = '0;
    Mem_Rd = 1'b0;
    @(posedge CLK); #1;
    rst_n = 1'b1;
    Bus_RValid = 1'b1; Bus_RData = 32'h99999999;
    @(posedge CLK); #1;
    Bus_RValid = 1'b0;
    @(negedge CLK);
    check("late_rvalid_ld", Ld_Data, 0);
    check("late_rvalid_req", Bus_Req, 0);
    @(posedge CLK); #1;
    access(0, 0, 3'b010, 32'h204, 32'h0, 32'h0F0F0F0F, 1, 2);

    check("queues_drained", done_q.size() + req_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
